// File: rtl/bp_nonsynth_mem_latency_pipe.sv
// bp_nonsynth_mem_latency_pipe: in-order delay pipe with a per-entry runtime latency and a release gap throttle.
module bp_nonsynth_mem_latency_pipe #(
    parameter int width_p         = 576,
    parameter int els_p           = 16,
    parameter int latency_width_p = 16,
    parameter int gap_width_p     = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [latency_width_p-1:0] latency_i,
    input  logic [gap_width_p-1:0]     gap_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    output logic [width_p-1:0]         data_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);
    logic [width_p-1:0]         mem    [els_p];
    logic [latency_width_p-1:0] wait_q [els_p];
    logic [ptr_w-1:0]           wr_ptr, rd_ptr;
    logic [gap_width_p-1:0]     gap_cnt;
    logic                       enq, deq;
    assign ready_and_o = (count_o != cnt_w'(els_p)) & reset_n_i;
    assign enq         = v_i & ready_and_o;
    assign deq         = yumi_i & v_o;
    assign v_o         = (count_o != '0) & (wait_q[rd_ptr] == '0) & (gap_cnt == '0);
    assign data_o      = mem[rd_ptr];
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            gap_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= (wr_ptr == ptr_w'(els_p-1)) ? '0 : wr_ptr + 1'b1;
            if (deq) rd_ptr <= (rd_ptr == ptr_w'(els_p-1)) ? '0 : rd_ptr + 1'b1;
            count_o <= count_o + cnt_w'(enq) - cnt_w'(deq);
            gap_cnt <= deq ? gap_i : (gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
        end
    // Every countdown ticks toward zero and stays there; a freshly written entry restarts at latency_i.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < els_p; i++)
                if (enq && wr_ptr == ptr_w'(i)) wait_q[i] <= latency_i;
                else if (wait_q[i] != '0) wait_q[i] <= wait_q[i] - 1'b1;
        end
    always_ff @(posedge clk_i)
        if (enq) mem[wr_ptr] <= data_i;
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));
endmodule

// File: tb/tb_bp_nonsynth_mem_latency_pipe.sv
// tb_bp_nonsynth_mem_latency_pipe: random and directed stimulus checked by a cycle-level queue model.
module tb_bp_nonsynth_mem_latency_pipe;
    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [15:0]  latency_i = '0;
    logic [7:0]   gap_i = '0;
    logic [575:0] data_i = '0;
    logic         v_i = 1'b0;
    logic         ready_and_o;
    logic [575:0] data_o;
    logic         v_o;
    logic         yumi_i = 1'b0;
    logic [4:0]   count_o;

    typedef struct { logic [575:0] d; longint ripe; } ent_t;
    ent_t   q[$];
    longint cyc = 0;
    longint gap_ok = 0;
    int     total = 0;
    int     pass = 0;
    bit     done = 1'b0;

    bp_nonsynth_mem_latency_pipe dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .latency_i(latency_i), .gap_i(gap_i),
        .data_i(data_i), .v_i(v_i), .ready_and_o(ready_and_o), .data_o(data_o),
        .v_o(v_o), .yumi_i(yumi_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [575:0] a, input logic [575:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // Model: an entry is releasable once its ripe cycle has come, it is at the head, and the gap has elapsed.
    always begin
        int n;
        bit ev;
        @(negedge clk_i or negedge reset_n_i);
        if (!reset_n_i) begin
            #1;
            chk("rst_v_o", longint'(v_o), 0);
            chk("rst_count", longint'(count_o), 0);
            chk("rst_ready", longint'(ready_and_o), 0);
            q.delete();
            gap_ok = 0;
        end else if (done) begin
            chk("final_empty", longint'(q.size()), 0);
            $display("%0d/%0d checks passed", pass, total);
            $finish;
        end else begin
            n = q.size();
            ev = n != 0 && cyc >= q[0].ripe && cyc >= gap_ok;
            chk("v_o", longint'(v_o), longint'(ev));
            chk("count", longint'(count_o), longint'(n));
            chk("ready", longint'(ready_and_o), longint'(n < 16));
            if (v_o && yumi_i && n != 0) begin
                chk("data", data_o, q[0].d);
                void'(q.pop_front());
                gap_ok = cyc + 1 + longint'(gap_i);
            end
            if (v_i && n < 16) q.push_back('{data_i, cyc + 1 + longint'(latency_i)});
        end
    end

    // ym: 0 never take, 1 take whenever offered, 2 take at random when offered
    task automatic step(input logic v, input logic [15:0] lat, input logic [7:0] g, input int ym);
        logic [575:0] d;
        for (int k = 0; k < 18; k++) d[k*32 +: 32] = $urandom;
        #1;
        v_i = v;
        data_i = d;
        latency_i = lat;
        gap_i = g;
        yumi_i = v_o & (ym == 1 || (ym == 2 && $urandom_range(0, 1) == 1));
        @(posedge clk_i);
    endtask

    task automatic drain(input logic [7:0] g);
        for (int k = 0; k < 600 && q.size() != 0; k++) step(1'b0, 16'd0, g, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        @(posedge clk_i);
        for (int k = 0; k < 20 && cyc < 10; k++) step(1'b0, 16'd0, 8'd0, 0);
        step(1'b1, 16'd100, 8'd0, 1);
        drain(8'd0);
        for (int k = 0; k < 20; k++) step(1'b1, 16'd0, 8'd0, 1);
        drain(8'd0);
        for (int k = 0; k < 18; k++) step(1'b1, 16'd50, 8'd0, 0);
        for (int k = 0; k < 70; k++) step(1'b1, 16'd50, 8'd0, 1);
        drain(8'd0);
        step(1'b1, 16'd40, 8'd0, 1);
        step(1'b1, 16'd2, 8'd0, 1);
        drain(8'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 16'd0, 8'd0, 0);
        drain(8'd3);
        for (int k = 0; k < 3; k++) step(1'b1, 16'd0, 8'd0, 0);
        for (int k = 0; k < 2; k++) step(1'b1, 16'd200, 8'd0, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 16'd0, 8'd0, 0);
        #1;
        v_i = 1'b0;
        yumi_i = 1'b0;
        #2 reset_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        @(posedge clk_i);
        for (int k = 0; k < 40; k++) step(1'b1, 16'd0, 8'd0, 1);
        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 20)), 8'($urandom_range(0, 2)), 2);
        drain(8'd1);
        #1;
        v_i = 1'b0;
        yumi_i = 1'b0;
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d pass=%0d", total, pass);
        $fatal(1);
    end
endmodule
